stream_join_n: RTL
==================

Name: stream_join_n

Overview:
- Parametrised N-input operand join for the stb/ack streaming fabric that links file readers, arithmetic cores and file writers.
- Generalises the fixed two-reader wiring in front of the double multiplier.
- Each of NUM_IN producer channels is captured independently into a holding register.
- Once every channel holds an operand, the concatenated bundle is presented on a single stb/ack output, so any N-operand core can sit behind a single join.

Parameters:
- WIDTH, 64, bits per operand channel.
- NUM_IN, 2, number of input channels (1..16).
- CNT_W, 32, width of performance counters (used only with JOIN_PERF_CNT_EN).

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- input_stb  input  NUM_IN  per-channel producer strobe.
- input_ack  output  NUM_IN  per-channel acknowledge.
- output_z  output  NUM_IN*WIDTH  bundle; channel i at [i*WIDTH +: WIDTH].
- output_z_stb  output  1  bundle valid.
- output_z_ack  input  1  consumer acknowledge.
- bundle_count  output  CNT_W  bundles delivered (JOIN_PERF_CNT_EN only).
- stall_count  output  CNT_W  output backpressure cycles (JOIN_PERF_CNT_EN only).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; assertion immediately clears all state.
- Transfer rule: a transfer occurs on a rising edge where stb and ack are both high. A producer holds stb and its data stable until that edge.
- Reset values:
  - full[i]=0, so input_ack = all ones.
  - output_z_stb=0, output_z=0.
  - Counters = 0.
- input_ack[i] = ~full[i]. It is driven only from registers, with no combinational path from any input.
- Channel capture: on a transfer on channel i, hold[i] <= input_data slice and full[i] <= 1.
  - Channels fill in any order and at any relative time.
  - A full channel does not accept further data until the bundle launches.
- Launch condition: all full[i]=1 AND (output_z_stb=0 OR output_z_ack=1).
- Launch action, on the same edge:
  - output_z <= {hold[NUM_IN-1..0]}, output_z_stb <= 1.
  - All full[i] <= 0.
- Output handshake: output_z_stb stays high and output_z stays stable until an edge with output_z_ack=1.
  - If no launch occurs on that edge, output_z_stb <= 0.
  - Launch coinciding with ack gives back-to-back bundles with no bubble.
- State per channel: EMPTY -> FULL on transfer; FULL -> EMPTY on launch.
- Output register states: IDLE -> VALID on launch; VALID -> IDLE on ack without launch; VALID -> VALID on ack with launch.
- Latency: output_z_stb rises one edge after the last channel's capture edge.
- Throughput: one bundle per 2 cycles when all producers and the consumer are always ready.
- Boundary: a channel cannot capture and launch on the same edge, because launch requires full already set.
- Boundary: output_z_ack while output_z_stb=0 is ignored.
- Boundary: NUM_IN=1 degenerates to a 2-entry pipeline register (hold + output).
- Reset mid-operation: partially collected operands and any pending bundle are discarded. The bench must re-send them.

Optional Feature:
- Macro: JOIN_PERF_CNT_EN.
- When defined:
  - bundle_count increments on each output transfer (output_z_stb & output_z_ack).
  - stall_count increments each cycle output_z_stb=1 and output_z_ack=0.
  - Both counters saturate at all ones and clear on rst.
- When undefined: both ports and their registers are absent, and all other behaviour is identical.

Decomposition:
- Package join_pkg holds:
  - the default CNT_W constant;
  - localparam limits (MAX_NUM_IN=16);
  - the channel-state enum (CH_EMPTY, CH_FULL);
  - the output-state enum (OUT_IDLE, OUT_VALID).
- Sub-module join_channel_reg: one per channel, containing the hold register, full flag and ack generation. It takes a launch input and exposes full and hold.
- The top generates NUM_IN instances plus the launch logic and the output register.

Test Plan:
- Single bundle, NUM_IN=2, WIDTH=64:
  - Stimulus: ch0 = 0x4000000000000000 (2.0), then ch1 = 0x4008000000000000 (3.0) two cycles later; ack held high.
  - Response: output_z = {0x4008000000000000, 0x4000000000000000}, stb high exactly one edge after ch1 capture, then low after ack.
- Backpressure:
  - Stimulus: output_z_ack=0 for 5 cycles while the next operands arrive.
  - Response: output_z stays stable; both input_ack fall after capture; stall_count=5 (feature on).
- Back-to-back:
  - Stimulus: all stb and ack tied high for 20 cycles with incrementing data.
  - Response: 10 bundles in order, no duplicates or losses, bundle_count=10.
- Skewed arrival, NUM_IN=4:
  - Stimulus: channels arrive in order 3,0,2,1 with gaps of 0-3 cycles.
  - Response: a single bundle {d3,d2,d1,d0}; each input_ack low from its capture until launch.
- Reset mid-operation:
  - Stimulus: rst asserted asynchronously after only ch0 is captured, with the previous bundle still pending.
  - Response: immediately output_z_stb=0 and input_ack=all ones. After reset only fresh operands appear in output_z.
- Counter saturation, CNT_W=4:
  - Stimulus: 20 bundles.
  - Response: bundle_count holds at 15.

Source files
------------

// File: rtl/join_pkg.sv
// Shared constants and state encodings for the N-input stb/ack operand join.
package join_pkg;

    localparam int unsigned DEFAULT_CNT_W = 32;
    localparam int unsigned MAX_NUM_IN    = 16;

    typedef enum logic {
        CH_EMPTY,
        CH_FULL
    } ch_state_e;

    typedef enum logic {
        OUT_IDLE,
        OUT_VALID
    } out_state_e;

endpackage

// File: rtl/join_channel_reg.sv
// One operand channel of the join: holding register, full flag and registered acknowledge.
module join_channel_reg
    import join_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_stb,
    output logic             in_ack,
    input  logic             launch,
    output logic             full,
    output logic [WIDTH-1:0] hold
);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CH_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture is only possible while empty, so launch never races a capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (in_stb && (state_q == CH_EMPTY)) begin
            hold_q <= in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CH_EMPTY: if (in_stb) state_d = CH_FULL;
            CH_FULL:  if (launch) state_d = CH_EMPTY;
        endcase
    end

    always_comb begin
        full   = (state_q == CH_FULL);
        in_ack = (state_q == CH_EMPTY);
        hold   = hold_q;
    end

endmodule

// File: rtl/stream_join_n.sv
// N-input stb/ack operand join: collects one operand per channel, then emits the bundle.
// Optional performance counters are enabled with the JOIN_PERF_CNT_EN macro.
module stream_join_n
    import join_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] input_data,
    input  logic [NUM_IN-1:0]       input_stb,
    output logic [NUM_IN-1:0]       input_ack,
    output logic [NUM_IN*WIDTH-1:0] output_z,
    output logic                    output_z_stb,
    input  logic                    output_z_ack
`ifdef JOIN_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]        bundle_count,
    output logic [CNT_W-1:0]        stall_count
`endif
);

    if (NUM_IN < 1 || NUM_IN > MAX_NUM_IN || CNT_W < 1) begin : g_bad_cfg
        $error("stream_join_n: unsupported NUM_IN or CNT_W");
    end

    logic [NUM_IN-1:0]       full;
    logic [NUM_IN*WIDTH-1:0] hold_flat;
    logic                    launch;
    out_state_e              out_q, out_d;
    logic [NUM_IN*WIDTH-1:0] z_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        join_channel_reg #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_data(input_data[i*WIDTH +: WIDTH]),
            .in_stb (input_stb[i]),
            .in_ack (input_ack[i]),
            .launch (launch),
            .full   (full[i]),
            .hold   (hold_flat[i*WIDTH +: WIDTH])
        );
    end

    // Launch may coincide with the consumer ack, giving bubble-free back-to-back bundles.
    assign launch = (&full) && ((out_q == OUT_IDLE) || output_z_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= OUT_IDLE;
        end else begin
            out_q <= out_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= '0;
        end else if (launch) begin
            z_q <= hold_flat;
        end
    end

    always_comb begin
        out_d = out_q;
        unique case (out_q)
            OUT_IDLE:  if (launch) out_d = OUT_VALID;
            OUT_VALID: if (output_z_ack && !launch) out_d = OUT_IDLE;
        endcase
    end

    always_comb begin
        output_z_stb = (out_q == OUT_VALID);
        output_z     = z_q;
    end

`ifdef JOIN_PERF_CNT_EN
    logic [CNT_W-1:0] bundle_q, stall_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
            stall_q  <= '0;
        end else begin
            if (output_z_stb && output_z_ack && (bundle_q != '1)) begin
                bundle_q <= bundle_q + CNT_W'(1);
            end
            if (output_z_stb && !output_z_ack && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bundle_count = bundle_q;
    assign stall_count  = stall_q;
`endif

endmodule
